// File: rtl/unit_rw_arbiter.sv
// unit_rw_arbiter: round-robin serializer of unit write/read requests onto one memory port.
// Define UNIT_ARB_TIMEOUT_EN to bound the mem_ack wait to TIMEOUT_CYCLES.
module unit_rw_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 14,
    parameter int ADDR_LIMIT     = 4096,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  unit_wen,
    input  logic [ADDR_WIDTH-1:0] unit_waddr,
    input  logic [DATA_WIDTH-1:0] unit_wdata,
    output logic                  unit_wack,
    output logic                  unit_invalid_waddr,
    input  logic                  unit_ren,
    input  logic [ADDR_WIDTH-1:0] unit_raddr,
    output logic                  unit_rstrb,
    output logic                  unit_invalid_raddr,
    output logic [DATA_WIDTH-1:0] unit_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic                  mem_err,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, COOL} state_t;
    localparam logic [63:0] LIMIT = 64'(ADDR_LIMIT);
    state_t                state;
    logic                  last_w;
    logic                  reject;
    logic                  grant_w;
    logic [ADDR_WIDTH-1:0] gaddr;
    logic                  in_range;
    logic                  expired;
    logic                  done;
    logic                  fail;
    logic [DATA_WIDTH-1:0] rdata_nxt;
    assign grant_w   = unit_wen & (~unit_ren | ~last_w);
    assign gaddr     = grant_w ? unit_waddr : unit_raddr;
    assign in_range  = 64'(gaddr) < LIMIT;
    assign done      = reject | mem_ack | expired;
    // a rejected access or a timeout always fails; a real completion reports mem_err
    assign fail      = reject | ~mem_ack | mem_err;
    assign rdata_nxt = (reject | ~mem_ack) ? '0 : mem_rdata;
`ifdef UNIT_ARB_TIMEOUT_EN
    logic [$clog2(TIMEOUT_CYCLES+1)-1:0] cnt;
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
        if (!s_axi_aresetn) cnt <= '0;
        else cnt <= (state == BUSY) ? cnt + 1'b1 : '0;
    assign expired = (state == BUSY) && !reject && (32'(cnt) == TIMEOUT_CYCLES - 1);
`else
    assign expired = 1'b0;
`endif
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state              <= IDLE;
            last_w             <= 1'b0;
            reject             <= 1'b0;
            unit_wack          <= 1'b0;
            unit_invalid_waddr <= 1'b0;
            unit_rstrb         <= 1'b0;
            unit_invalid_raddr <= 1'b0;
            unit_rdata         <= '0;
            mem_req            <= 1'b0;
            mem_we             <= 1'b0;
            mem_addr           <= '0;
            mem_wdata          <= '0;
        end else begin
            unit_wack  <= 1'b0;
            unit_rstrb <= 1'b0;
            case (state)
                IDLE: if (unit_wen || unit_ren) begin
                    last_w <= grant_w;
                    reject <= ~in_range;
                    state  <= BUSY;
                    if (in_range) begin
                        mem_req   <= 1'b1;
                        mem_we    <= grant_w;
                        mem_addr  <= gaddr;
                        mem_wdata <= unit_wdata;
                    end
                end
                BUSY: if (done) begin
                    mem_req <= 1'b0;
                    state   <= COOL;
                    if (last_w) begin
                        unit_wack          <= 1'b1;
                        unit_invalid_waddr <= fail;
                    end else begin
                        unit_rstrb         <= 1'b1;
                        unit_invalid_raddr <= fail;
                        unit_rdata         <= rdata_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_unit_rw_arbiter.sv
// tb_unit_rw_arbiter: directed and randomized checks of unit_rw_arbiter against a transaction-level model.
module tb_unit_rw_arbiter;
    localparam int LIMIT = 4096;
    localparam int TO    = 8;
    logic        s_axi_aclk = 0;
    logic        s_axi_aresetn = 0;
    logic        unit_wen = 0, unit_ren = 0;
    logic [13:0] unit_waddr = 0, unit_raddr = 0;
    logic [31:0] unit_wdata = 0;
    logic        unit_wack, unit_invalid_waddr, unit_rstrb, unit_invalid_raddr;
    logic [31:0] unit_rdata;
    logic        mem_req, mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 0, mem_err = 0;
    logic [31:0] mem_rdata = 0;
    int          checks = 0, fails = 0;
    int          ack_delay = 1, wait_cnt = 0, n_access = 0;
    logic        err_next = 0;
    logic [31:0] rdata_next = 0;
    logic        seen_we;
    logic [13:0] seen_addr;
    logic [31:0] seen_wdata;
    logic        mlw = 0;

    unit_rw_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(14), .ADDR_LIMIT(LIMIT), .TIMEOUT_CYCLES(TO)) dut (
        .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
        .unit_wen(unit_wen), .unit_waddr(unit_waddr), .unit_wdata(unit_wdata),
        .unit_wack(unit_wack), .unit_invalid_waddr(unit_invalid_waddr),
        .unit_ren(unit_ren), .unit_raddr(unit_raddr), .unit_rstrb(unit_rstrb),
        .unit_invalid_raddr(unit_invalid_raddr), .unit_rdata(unit_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata)
    );

    always #5 s_axi_aclk = ~s_axi_aclk;

    // memory responder: acks after ack_delay cycles of mem_req (0 = never)
    always @(negedge s_axi_aclk) begin
        mem_ack = 0;
        if (mem_req) begin
            wait_cnt++;
            if (ack_delay != 0 && wait_cnt == ack_delay) begin
                mem_ack = 1; mem_err = err_next; mem_rdata = rdata_next;
                seen_we = mem_we; seen_addr = mem_addr; seen_wdata = mem_wdata;
                n_access++; wait_cnt = 0;
            end
        end else wait_cnt = 0;
    end

    task automatic tick;
        @(negedge s_axi_aclk);
    endtask

    task automatic wait_pulse(output int cyc, output int req_cyc);
        cyc = -1; req_cyc = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge s_axi_aclk);
            req_cyc += int'(mem_req);
            if (unit_wack || unit_rstrb) begin cyc = i; break; end
        end
    endtask

    task automatic test_reset;
        s_axi_aresetn = 0;
        repeat (2) tick();
        checks++;
        if ({mem_req, mem_we, unit_wack, unit_rstrb, unit_invalid_waddr, unit_invalid_raddr} !== 6'b0) begin
            fails++; $display("FAIL reset_ctrl got %b want 000000", {mem_req, mem_we, unit_wack, unit_rstrb, unit_invalid_waddr, unit_invalid_raddr});
        end
        checks++;
        if ({mem_addr, mem_wdata, unit_rdata} !== 78'b0) begin
            fails++; $display("FAIL reset_data got %h/%h/%h want 0", mem_addr, mem_wdata, unit_rdata);
        end
        s_axi_aresetn = 1; mlw = 0;
        tick();
    endtask

    task automatic test_write;
        int c, rq;
        ack_delay = 1; err_next = 0;
        unit_wen = 1; unit_waddr = 14'h10; unit_wdata = 32'hA5A5A5A5;
        wait_pulse(c, rq); mlw = 1;
        checks++;
        if (c !== 2) begin fails++; $display("FAIL wr_latency got %0d want 2", c); end
        checks++;
        if ({unit_wack, unit_rstrb, unit_invalid_waddr} !== 3'b100) begin
            fails++; $display("FAIL wr_pulse got %b want 100", {unit_wack, unit_rstrb, unit_invalid_waddr});
        end
        checks++;
        if ({seen_we, seen_addr, seen_wdata} !== {1'b1, 14'h10, 32'hA5A5A5A5}) begin
            fails++; $display("FAIL wr_mem got we=%b addr=%h data=%h want 1/0010/a5a5a5a5", seen_we, seen_addr, seen_wdata);
        end
        unit_wen = 0;
        tick();
        checks++;
        if (unit_wack !== 1'b0) begin fails++; $display("FAIL wr_single_pulse got %b want 0", unit_wack); end
    endtask

    task automatic test_tie;
        int c, rq;
        s_axi_aresetn = 0; tick(); s_axi_aresetn = 1; mlw = 0; tick();
        ack_delay = 1; err_next = 0; rdata_next = 32'h0BADF00D;
        unit_wen = 1; unit_waddr = 14'h40; unit_wdata = 32'h1; unit_ren = 1; unit_raddr = 14'h44;
        wait_pulse(c, rq);
        checks++;
        if ({unit_wack, unit_rstrb} !== 2'b10) begin fails++; $display("FAIL tie1_write_first got %b want 10", {unit_wack, unit_rstrb}); end
        unit_wen = 0;
        tick();
        unit_wen = 1; unit_wdata = 32'h2;
        wait_pulse(c, rq);
        checks++;
        if ({unit_wack, unit_rstrb} !== 2'b01) begin fails++; $display("FAIL tie2_read_first got %b want 01", {unit_wack, unit_rstrb}); end
        checks++;
        if (unit_rdata !== 32'h0BADF00D) begin fails++; $display("FAIL tie_rdata got %h want 0badf00d", unit_rdata); end
        unit_ren = 0;
        wait_pulse(c, rq);
        checks++;
        if ({unit_wack, unit_rstrb, seen_wdata} !== {2'b10, 32'h2}) begin
            fails++; $display("FAIL tie2_write_next got %b/%h want 10/00000002", {unit_wack, unit_rstrb}, seen_wdata);
        end
        unit_wen = 0; mlw = 1;
        tick();
    endtask

    task automatic test_read;
        int c, rq;
        ack_delay = 5; err_next = 0; rdata_next = 32'h12345678;
        unit_ren = 1; unit_raddr = 14'h20;
        wait_pulse(c, rq); mlw = 0;
        checks++;
        if (rq !== 5 || c !== 6) begin fails++; $display("FAIL rd_hold got req=%0d lat=%0d want 5/6", rq, c); end
        checks++;
        if ({unit_rstrb, unit_invalid_raddr, unit_rdata} !== {2'b10, 32'h12345678}) begin
            fails++; $display("FAIL rd_result got %b/%b/%h want 1/0/12345678", unit_rstrb, unit_invalid_raddr, unit_rdata);
        end
        checks++;
        if ({seen_we, seen_addr} !== {1'b0, 14'h20}) begin fails++; $display("FAIL rd_mem got %b/%h want 0/0020", seen_we, seen_addr); end
        unit_ren = 0;
        tick();
        checks++;
        if ({unit_rstrb, unit_rdata} !== {1'b0, 32'h12345678}) begin
            fails++; $display("FAIL rd_hold_data got %b/%h want 0/12345678", unit_rstrb, unit_rdata);
        end
    endtask

    task automatic test_range;
        int c, rq, na;
        ack_delay = 1; err_next = 0;
        na = n_access;
        unit_wen = 1; unit_waddr = 14'(LIMIT); unit_wdata = 32'hFFFF0000;
        wait_pulse(c, rq); mlw = 1;
        checks++;
        if (rq !== 0 || n_access !== na) begin fails++; $display("FAIL oor_no_req got req=%0d acc=%0d want 0/%0d", rq, n_access, na); end
        checks++;
        if ({c, unit_wack, unit_invalid_waddr} !== {32'd2, 2'b11}) begin
            fails++; $display("FAIL oor_wack got lat=%0d %b/%b want 2/1/1", c, unit_wack, unit_invalid_waddr);
        end
        unit_wen = 0; tick();
        unit_wen = 1; unit_waddr = 14'(LIMIT - 1);
        wait_pulse(c, rq);
        checks++;
        if ({unit_invalid_waddr, seen_addr} !== {1'b0, 14'(LIMIT - 1)}) begin
            fails++; $display("FAIL edge_addr got %b/%h want 0/%h", unit_invalid_waddr, seen_addr, 14'(LIMIT - 1));
        end
        unit_wen = 0; tick();
        err_next = 1; rdata_next = 32'hDEADBEEF;
        unit_ren = 1; unit_raddr = 14'h60;
        wait_pulse(c, rq); mlw = 0;
        checks++;
        if ({unit_rstrb, unit_invalid_raddr} !== 2'b11) begin fails++; $display("FAIL rd_err got %b want 11", {unit_rstrb, unit_invalid_raddr}); end
        unit_ren = 0; tick();
        unit_ren = 1; unit_raddr = 14'h3000;
        wait_pulse(c, rq);
        checks++;
        if ({unit_rstrb, unit_invalid_raddr, unit_rdata} !== {2'b11, 32'h0}) begin
            fails++; $display("FAIL oor_rd got %b/%b/%h want 1/1/0", unit_rstrb, unit_invalid_raddr, unit_rdata);
        end
        unit_ren = 0; err_next = 0; tick();
    endtask

    task automatic test_random;
        logic [13:0] wa, ra, a;
        logic [31:0] wd;
        logic        ew, bad, first;
        int          c, rq, na, k, e_lat;
        for (int t = 0; t < 40; t++) begin
            k = $urandom_range(1, 3);
            wa = ($urandom_range(0, 3) == 0) ? 14'(LIMIT + $urandom_range(0, 12287)) : 14'($urandom_range(0, LIMIT - 1));
            ra = ($urandom_range(0, 3) == 0) ? 14'(LIMIT + $urandom_range(0, 12287)) : 14'($urandom_range(0, LIMIT - 1));
            wd = $urandom;
            ack_delay = $urandom_range(1, 4); err_next = ($urandom_range(0, 3) == 0); rdata_next = $urandom;
            unit_wen = k[0]; unit_ren = k[1]; unit_waddr = wa; unit_raddr = ra; unit_wdata = wd;
            first = 1;
            while (unit_wen || unit_ren) begin
                ew = (unit_wen && unit_ren) ? !mlw : unit_wen;
                mlw = ew;
                a = ew ? wa : ra;
                bad = (int'(a) >= LIMIT);
                na = n_access;
                e_lat = (bad ? 2 : ack_delay + 1) + (first ? 0 : 1);
                wait_pulse(c, rq);
                checks++;
                if (c !== e_lat) begin fails++; $display("FAIL rnd_latency t=%0d got %0d want %0d", t, c, e_lat); end
                checks++;
                if ({unit_wack, unit_rstrb} !== {ew, !ew}) begin fails++; $display("FAIL rnd_grant t=%0d got %b want %b", t, {unit_wack, unit_rstrb}, {ew, !ew}); end
                checks++;
                if ((ew ? unit_invalid_waddr : unit_invalid_raddr) !== (bad | err_next)) begin
                    fails++; $display("FAIL rnd_invalid t=%0d got %b want %b", t, ew ? unit_invalid_waddr : unit_invalid_raddr, bad | err_next);
                end
                checks++;
                if (n_access !== na + int'(!bad)) begin fails++; $display("FAIL rnd_access t=%0d got %0d want %0d", t, n_access, na + int'(!bad)); end
                if (!bad) begin
                    checks++;
                    if ({seen_we, seen_addr} !== {ew, a}) begin fails++; $display("FAIL rnd_mem t=%0d got %b/%h want %b/%h", t, seen_we, seen_addr, ew, a); end
                end
                if (!bad && ew) begin
                    checks++;
                    if (seen_wdata !== wd) begin fails++; $display("FAIL rnd_wdata t=%0d got %h want %h", t, seen_wdata, wd); end
                end
                if (!ew) begin
                    checks++;
                    if (unit_rdata !== (bad ? 32'h0 : rdata_next)) begin
                        fails++; $display("FAIL rnd_rdata t=%0d got %h want %h", t, unit_rdata, bad ? 32'h0 : rdata_next);
                    end
                end
                if (ew) unit_wen = 0; else unit_ren = 0;
                first = 0;
            end
            tick();
        end
        err_next = 0;
    endtask

    task automatic test_async_reset;
        int c, rq;
        ack_delay = 50;
        unit_wen = 1; unit_waddr = 14'h50; unit_wdata = 32'h55;
        repeat (3) tick();
        checks++;
        if (mem_req !== 1'b1) begin fails++; $display("FAIL ar_busy got %b want 1", mem_req); end
        #2 s_axi_aresetn = 0;
        #1;
        checks++;
        if ({mem_req, mem_we, unit_wack, unit_rstrb, unit_invalid_waddr, unit_invalid_raddr} !== 6'b0) begin
            fails++; $display("FAIL ar_immediate got %b want 000000", {mem_req, mem_we, unit_wack, unit_rstrb, unit_invalid_waddr, unit_invalid_raddr});
        end
        unit_wen = 0;
        tick();
        s_axi_aresetn = 1; mlw = 0; ack_delay = 1;
        unit_wen = 1; unit_ren = 1; unit_raddr = 14'h54;
        wait_pulse(c, rq);
        checks++;
        if ({unit_wack, unit_rstrb} !== 2'b10) begin fails++; $display("FAIL ar_write_first got %b want 10", {unit_wack, unit_rstrb}); end
        unit_wen = 0;
        wait_pulse(c, rq);
        checks++;
        if ({unit_wack, unit_rstrb} !== 2'b01) begin fails++; $display("FAIL ar_read_next got %b want 01", {unit_wack, unit_rstrb}); end
        unit_ren = 0; mlw = 0;
        tick();
    endtask

    task automatic test_timeout;
        int c, rq;
        ack_delay = 0;
        unit_ren = 1; unit_raddr = 14'h30;
`ifdef UNIT_ARB_TIMEOUT_EN
        wait_pulse(c, rq);
        checks++;
        if (c !== TO + 1 || rq !== TO) begin fails++; $display("FAIL to_timing got lat=%0d req=%0d want %0d/%0d", c, rq, TO + 1, TO); end
        checks++;
        if ({unit_rstrb, unit_invalid_raddr, unit_rdata, mem_req} !== {2'b11, 32'h0, 1'b0}) begin
            fails++; $display("FAIL to_result got %b/%b/%h/%b want 1/1/0/0", unit_rstrb, unit_invalid_raddr, unit_rdata, mem_req);
        end
        unit_ren = 0; tick();
`else
        c = 0; rq = 0;
        repeat (1000) begin tick(); c += int'(mem_req); rq += int'(unit_rstrb); end
        checks++;
        if (c !== 1000 || rq !== 0) begin fails++; $display("FAIL no_timeout got req=%0d strb=%0d want 1000/0", c, rq); end
        unit_ren = 0; s_axi_aresetn = 0; tick(); s_axi_aresetn = 1; tick();
`endif
        mlw = 0; ack_delay = 1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_tie();
        test_read();
        test_range();
        test_random();
        test_async_reset();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
